// File: rtl/axi_lite_up_bridge.sv
// AXI4-Lite slave to up_ request/acknowledge register bus bridge.
// Independent write and read FSMs turn AXI handshakes into single-cycle up_ strobes.
module axi_lite_up_bridge #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                     aclk,
  input  logic                     arstn,
  input  logic                     s_axi_awvalid,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  output logic                     s_axi_awready,
  input  logic                     s_axi_wvalid,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  output logic                     s_axi_wready,
  output logic                     s_axi_bvalid,
  output logic [1:0]               s_axi_bresp,
  input  logic                     s_axi_bready,
  input  logic                     s_axi_arvalid,
  input  logic [ADDRESS_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  output logic                     s_axi_arready,
  output logic                     s_axi_rvalid,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  input  logic                     s_axi_rready,
  output logic                     up_wreq,
  output logic [ADDRESS_WIDTH-3:0] up_waddr,
  output logic [31:0]              up_wdata,
  input  logic                     up_wack,
  output logic                     up_rreq,
  output logic [ADDRESS_WIDTH-3:0] up_raddr,
  input  logic [31:0]              up_rdata,
  input  logic                     up_rack
);

  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [1:0]               w_state_q, w_state_d;
  logic [CntW-1:0]          w_cnt_q, w_cnt_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [ADDRESS_WIDTH-3:0] waddr_q, waddr_d;
  logic [31:0]              wdata_q, wdata_d;

  logic [1:0]               r_state_q, r_state_d;
  logic [CntW-1:0]          r_cnt_q, r_cnt_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [ADDRESS_WIDTH-3:0] raddr_q, raddr_d;
  logic [31:0]              rdata_q, rdata_d;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Write path: AW and W are only taken together, never one alone.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    bresp_d   = bresp_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (w_state_q)
      StIdle: if (s_axi_awvalid && s_axi_wvalid) w_state_d = StAcc;
      StAcc: begin
        waddr_d   = s_axi_awaddr[ADDRESS_WIDTH-1:2];
        wdata_d   = s_axi_wdata;
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        if (up_wack) begin
          bresp_d   = RespOkay;
          w_state_d = StResp;
        end else if (w_cnt_q == CntMax) begin
          bresp_d   = RespSlverr;
          w_state_d = StResp;
        end else begin
          w_cnt_d = w_cnt_q + CntW'(1);
        end
      end
      StResp: if (s_axi_bready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    rresp_d   = rresp_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      StIdle: if (s_axi_arvalid) r_state_d = StAcc;
      StAcc: begin
        raddr_d   = s_axi_araddr[ADDRESS_WIDTH-1:2];
        r_cnt_d   = '0;
        r_state_d = StWait;
      end
      StWait: begin
        if (up_rack) begin
          rdata_d   = up_rdata;
          rresp_d   = RespOkay;
          r_state_d = StResp;
        end else if (r_cnt_q == CntMax) begin
          rdata_d   = '0;
          rresp_d   = RespSlverr;
          r_state_d = StResp;
        end else begin
          r_cnt_d = r_cnt_q + CntW'(1);
        end
      end
      StResp: if (s_axi_rready) r_state_d = StIdle;
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      w_state_q <= StIdle;
      w_cnt_q   <= '0;
      bresp_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      r_state_q <= StIdle;
      r_cnt_q   <= '0;
      rresp_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      rresp_q   <= rresp_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
    end
  end

  // The counter only sits at zero in the first WAIT cycle, which marks the strobe.
  assign s_axi_awready = (w_state_q == StAcc);
  assign s_axi_wready  = (w_state_q == StAcc);
  assign s_axi_bvalid  = (w_state_q == StResp);
  assign s_axi_bresp   = bresp_q;
  assign up_wreq       = (w_state_q == StWait) && (w_cnt_q == '0);
  assign up_waddr      = waddr_q;
  assign up_wdata      = wdata_q;

  assign s_axi_arready = (r_state_q == StAcc);
  assign s_axi_rvalid  = (r_state_q == StResp);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign up_rreq       = (r_state_q == StWait) && (r_cnt_q == '0);
  assign up_raddr      = raddr_q;

endmodule

// File: tb/tb_axi_lite_up_bridge.sv
// Self-checking bench for axi_lite_up_bridge with a queue scoreboard and a delayed-ack responder.
module tb_axi_lite_up_bridge;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [2:0]  prot = 3'b0;
  logic [3:0]  wstrb = 4'hf;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        up_wreq, up_rreq, up_wack, up_rack;
  logic [29:0] up_waddr, up_raddr;
  logic [31:0] up_wdata, up_rdata;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0;
  int wreq_count = 0, wreq_cyc = 0, rreq_count = 0, rreq_cyc = 0;
  logic [29:0] wreq_addr, rreq_addr;
  logic [31:0] wreq_data;
  int w_ack_delay = -1, r_ack_delay = -1, w_left = -1, r_left = -1;
  logic w_ack_r = 0, r_ack_r = 0, w_force = 0;
  logic [31:0] r_ack_data = 0;
  exp_t wexp[$], rexp[$];

  assign up_wack  = w_ack_r | w_force;
  assign up_rack  = r_ack_r;
  assign up_rdata = r_ack_r ? r_ack_data : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  axi_lite_up_bridge #(.ADDRESS_WIDTH(32), .ACK_TIMEOUT(16)) dut (
    .aclk(clk), .arstn(arstn),
    .s_axi_awvalid(awvalid), .s_axi_awaddr(awaddr), .s_axi_awprot(prot),
    .s_axi_awready(awready),
    .s_axi_wvalid(wvalid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_araddr(araddr), .s_axi_arprot(prot),
    .s_axi_arready(arready),
    .s_axi_rvalid(rvalid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rready(rready),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  // Strobe monitor and delayed-ack responder, evaluated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (up_wreq === 1'b1) begin
      wreq_count++; wreq_cyc = cyc; wreq_addr = up_waddr; wreq_data = up_wdata;
      w_left = w_ack_delay;
    end else if (w_left >= 0) w_left--;
    if (up_rreq === 1'b1) begin
      rreq_count++; rreq_cyc = cyc; rreq_addr = up_raddr;
      r_left = r_ack_delay;
    end else if (r_left >= 0) r_left--;
    w_ack_r = (w_left == 0);
    r_ack_r = (r_left == 0);
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int delay,
                          input int lag, input int hold, input string tag);
    exp_t e;
    int n0, bcyc, bad, lat;
    bit seen;
    e.addr = addr[31:2]; e.data = data; e.resp = (delay < 0) ? 2'b10 : 2'b00;
    wexp.push_back(e);
    w_ack_delay = delay;
    n0 = wreq_count;
    @(negedge clk);
    awvalid = 1; awaddr = addr; wdata = data; wvalid = (lag == 0);
    bad = 0;
    for (int i = 0; i < lag; i++) begin
      @(negedge clk);
      if (awready !== 1'b0 || wready !== 1'b0 || up_wreq !== 1'b0) bad++;
    end
    wvalid = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL %s lone_aw: %0d ready cycles, need 0", tag, bad);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (awready === 1'b1 && wready === 1'b1);
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL %s aw_handshake: no ready seen", tag); end
    @(negedge clk);
    awvalid = 0; wvalid = 0; awaddr = $urandom; wdata = $urandom;
    bready = (hold == 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bvalid === 1'b1) seen = 1; else @(negedge clk);
    end
    bcyc = cyc;
    e = wexp.pop_front();
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL %s bvalid: never asserted", tag); end
    lat = (delay < 0) ? 16 : delay + 1;
    tests_run++;
    if (bcyc - wreq_cyc != lat) begin
      tests_failed++; $display("FAIL %s b_latency: got %0d need %0d", tag, bcyc - wreq_cyc, lat);
    end
    tests_run++;
    if (wreq_addr !== e.addr || wreq_data !== e.data) begin
      tests_failed++;
      $display("FAIL %s strobe_addr_data: got %h/%h need %h/%h", tag, wreq_addr, wreq_data,
               e.addr, e.data);
    end
    tests_run++;
    if (up_waddr !== e.addr || up_wdata !== e.data) begin
      tests_failed++;
      $display("FAIL %s held_addr_data: got %h/%h need %h/%h", tag, up_waddr, up_wdata,
               e.addr, e.data);
    end
    tests_run++;
    if (bresp !== e.resp) begin
      tests_failed++; $display("FAIL %s bresp: got %b need %b", tag, bresp, e.resp);
    end
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (bvalid !== 1'b1 || bresp !== e.resp) bad++;
      @(negedge clk);
    end
    if (hold > 0) begin
      tests_run++;
      if (bad != 0 || bvalid !== 1'b1) begin
        tests_failed++; $display("FAIL %s b_stable: %0d unstable cycles, need 0", tag, bad);
      end
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL %s bvalid_drop: got %b need 0", tag, bvalid);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (wreq_count - n0 != 1) begin
      tests_failed++; $display("FAIL %s wreq_pulses: got %0d need 1", tag, wreq_count - n0);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int delay,
                         input string tag);
    exp_t e;
    int n0, rcyc, lat;
    bit seen;
    e.addr = addr[31:2]; e.data = (delay < 0) ? 32'h0 : data;
    e.resp = (delay < 0) ? 2'b10 : 2'b00;
    rexp.push_back(e);
    r_ack_delay = delay; r_ack_data = data;
    n0 = rreq_count;
    @(negedge clk);
    arvalid = 1; araddr = addr;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (arready === 1'b1);
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL %s ar_handshake: no arready seen", tag); end
    @(negedge clk);
    arvalid = 0; araddr = $urandom; rready = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rvalid === 1'b1) seen = 1; else @(negedge clk);
    end
    rcyc = cyc;
    e = rexp.pop_front();
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL %s rvalid: never asserted", tag); end
    lat = (delay < 0) ? 16 : delay + 1;
    tests_run++;
    if (rcyc - rreq_cyc != lat) begin
      tests_failed++; $display("FAIL %s r_latency: got %0d need %0d", tag, rcyc - rreq_cyc, lat);
    end
    tests_run++;
    if (rreq_addr !== e.addr || up_raddr !== e.addr) begin
      tests_failed++;
      $display("FAIL %s raddr: got %h/%h need %h", tag, rreq_addr, up_raddr, e.addr);
    end
    tests_run++;
    if (rdata !== e.data || rresp !== e.resp) begin
      tests_failed++;
      $display("FAIL %s rdata_rresp: got %h/%b need %h/%b", tag, rdata, rresp, e.data, e.resp);
    end
    @(negedge clk);
    rready = 0;
    tests_run++;
    if (rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL %s rvalid_drop: got %b need 0", tag, rvalid);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (rreq_count - n0 != 1) begin
      tests_failed++; $display("FAIL %s rreq_pulses: got %0d need 1", tag, rreq_count - n0);
    end
  endtask

  task automatic test_reset();
    arstn = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, up_wreq, up_rreq} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b need 0",
               {awready, wready, bvalid, bresp, arready, rvalid, rresp, up_wreq, up_rreq});
    end
    tests_run++;
    if (rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h need 0", rdata);
    end
    tests_run++;
    if ({up_waddr, up_wdata, up_raddr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_up: got %h/%h/%h need 0", up_waddr, up_wdata, up_raddr);
    end
    arstn = 1;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    fork
      do_write(32'h0000_0010, 32'hCAFE_F00D, 0, 0, 0, "sim_wr");
      do_read(32'h0000_0014, 32'h0BAD_1DEA, 1, "sim_rd");
    join
    tests_run++;
    if (wreq_cyc != rreq_cyc) begin
      tests_failed++; $display("FAIL sim_strobes: wreq cyc %0d rreq cyc %0d", wreq_cyc, rreq_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int n0, bcount;
    bit seen;
    w_ack_delay = -1;
    n0 = wreq_count;
    @(negedge clk);
    awvalid = 1; wvalid = 1; awaddr = 32'h0000_0040; wdata = 32'h5555_AAAA;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (awready === 1'b1);
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; bready = 1;
    tests_run++;
    if (wreq_count - n0 != 1) begin
      tests_failed++; $display("FAIL rstmid_strobe: got %0d pulses need 1", wreq_count - n0);
    end
    @(negedge clk);
    arstn = 0;
    @(negedge clk);
    arstn = 1;
    tests_run++;
    if ({up_waddr, up_wdata} !== '0 || bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_clear: got %h/%h/%b need 0", up_waddr, up_wdata, bvalid);
    end
    w_force = 1;
    bcount = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) w_force = 0;
      @(negedge clk);
      if (bvalid === 1'b1) bcount++;
    end
    bready = 0;
    tests_run++;
    if (bcount != 0 || wreq_count - n0 != 1) begin
      tests_failed++;
      $display("FAIL rstmid_no_resp: bvalid cycles %0d, strobes %0d; need 0, 1", bcount,
               wreq_count - n0);
    end
    do_write(32'h0000_0044, 32'h1357_9BDF, 0, 0, 0, "after_rst");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    do_write(32'h0000_0008, 32'hA5A5_00FF, 1, 0, 0, "write_basic");
    do_read(32'h0000_000C, 32'h1234_5678, 2, "read_basic");
    do_write(32'h0000_0020, 32'hDEAD_0001, -1, 0, 0, "write_timeout");
    do_read(32'h0000_0024, 32'hFFFF_FFFF, -1, "read_timeout");
    do_write(32'h0000_0030, 32'h0F0F_F0F0, 0, 5, 4, "aw_before_w");
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
